// File: rtl/sync_reg_responder_if.sv
// ---------------------------------------------------------------------------
// sync_reg_responder_if
// Bundles the four-phase request side (req_async, data_async, ack) and the
// consumer-side FIFO read port (out_valid, out_data, out_ready, count) of
// the register-handshake responder.
//   slave  : the responder itself (drives ack and the FIFO read outputs)
//   master : the environment (initiator + consumer) driving req/data/ready
// Parameters:
//   WIDTH : data word width
//   DEPTH : FIFO entries, sets the width of count
// ---------------------------------------------------------------------------
interface sync_reg_responder_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             req_async;
  logic [WIDTH-1:0] data_async;
  logic             ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output req_async, data_async, out_ready,
    input  ack, out_valid, out_data, count
  );

  modport slave (
    input  req_async, data_async, out_ready,
    output ack, out_valid, out_data, count
  );
endinterface

// File: rtl/sync_reg_responder.sv
// ---------------------------------------------------------------------------
// sync_reg_responder
// Receiving end of a four-phase req/ack register handshake, living entirely
// in the consumer clock domain. The foreign request level is synchronized
// through NSYNC flops; the initiator's data word is held stable by protocol
// and is sampled directly in the capture cycle. Captured words are queued in
// a small first-word-fall-through FIFO. Ack is withheld while the FIFO is
// full, so back-pressure reaches the initiator without losing words.
// Ports:
//   clk        : single clock, all logic on posedge
//   rst        : synchronous, active-high reset
//   bus.slave  : req_async/data_async in, ack out (initiator side);
//                out_valid/out_data/count out, out_ready in (consumer side)
// Parameters:
//   WIDTH : data word width
//   DEPTH : FIFO entries, power of 2, >= 2
//   NSYNC : request synchronizer depth, >= 2
// ---------------------------------------------------------------------------
module sync_reg_responder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int NSYNC = 2
) (
  input logic                clk,
  input logic                rst,
  sync_reg_responder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_ACK_HI = 1'b1;
  localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] C_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  logic [NSYNC-1:0] r_sync;
  logic [0:0]       r_state;
  logic             r_ack;
  logic             r_valid;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_out_data;

  logic             w_req_s;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // Request synchronizer: shift the foreign level through NSYNC flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {NSYNC{1'b0}};
    end else begin
      r_sync <= {r_sync[NSYNC-2:0], bus.req_async};
    end
  end

  // Push/pop decisions and next-state values for the FIFO.
  always_comb begin
    w_req_s      = r_sync[NSYNC-1];
    // Full is judged on the registered count, so a pop in the same cycle
    // does not open room for a push until the following cycle.
    w_full       = (r_count == C_FULL);
    w_push       = (r_state == S_IDLE) && w_req_s && !w_full;
    w_pop        = (r_count != C_ZERO) && bus.out_ready;
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    w_head_nxt   = r_mem[r_rd_ptr];

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + P_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end

    // The word being written lands at the new head only when the FIFO is
    // (or is about to become) empty; otherwise the head comes from memory.
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = bus.data_async;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Handshake FSM: one capture per request, ack held until req drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state <= S_ACK_HI;
            r_ack   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end
        end
        S_ACK_HI: begin
          if (!w_req_s) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end else begin
            r_state <= S_ACK_HI;
            r_ack   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control: pointers, occupancy, valid flag and registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_count    <= C_ZERO;
      r_valid    <= 1'b0;
      r_out_data <= {WIDTH{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != C_ZERO);
      // Head only moves on push or pop; holding otherwise keeps out_data
      // stable even when the FIFO is empty.
      if (w_push || w_pop) begin
        r_out_data <= w_head_nxt;
      end
    end
  end

  // FIFO storage: data_async is sampled only in the capture cycle.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.data_async;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_out_data;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_sync_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_sync_reg_responder
// Directed latency/back-pressure/reset scenarios plus randomized traffic
// checked against a queue-based model of the initiator and consumer.
// ---------------------------------------------------------------------------
module tb_sync_reg_responder;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int NSYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sync_reg_responder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_reg_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NSYNC(NSYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (bus.ack !== lvl && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " ack wait"}, {31'd0, bus.ack}, {31'd0, lvl});
  endtask

  task automatic xfer(input logic [15:0] w, input string tag);
    bus.data_async = w;
    bus.req_async  = 1'b1;
    wait_ack(1'b1, tag);
    bus.req_async  = 1'b0;
    wait_ack(1'b0, tag);
  endtask

  task automatic pop_expect(input logic [15:0] w, input string tag);
    chk({tag, " valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, " data"}, {16'd0, bus.out_data}, {16'd0, w});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Initiator + consumer model: every requested word must come out exactly
  // once and in request order. rnd=0 gives back-to-back sequential words
  // with the consumer always ready.
  task automatic run_traffic(input int nwords, input bit rnd, input string tag);
    logic [15:0] exp_q[$];
    logic [15:0] w;
    int   sent = 0;
    int   got = 0;
    int   phase = 0;
    int   dly = 0;
    int   cyc = 0;
    int   acks = 0;
    logic prev_ack = 1'b0;
    while (got < nwords && cyc < 5000) begin
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        chk({tag, " queued"}, {31'd0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk({tag, " order"}, {16'd0, bus.out_data}, {16'd0, w});
          got++;
        end
      end
      chk({tag, " valid/count"}, {31'd0, bus.out_valid}, {31'd0, (bus.count != 0)});
      if (!rnd) chk({tag, " count<=1"}, {31'd0, (bus.count <= 1)}, 32'd1);
      if (bus.ack && !prev_ack) acks++;
      prev_ack = bus.ack;
      case (phase)
        0: begin
          if (sent < nwords) begin
            if (dly == 0) begin
              w = rnd ? 16'($urandom) : 16'(sent);
              bus.data_async = w;
              bus.req_async  = 1'b1;
              exp_q.push_back(w);
              sent++;
              phase = 1;
            end else begin
              dly--;
            end
          end
        end
        1: begin
          if (bus.ack) begin
            bus.req_async = 1'b0;
            if (rnd) bus.data_async = 16'($urandom);
            phase = 2;
          end
        end
        2: begin
          if (!bus.ack) begin
            phase = 0;
            dly = rnd ? $urandom_range(0, 4) : 0;
          end
        end
        default: phase = 0;
      endcase
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.req_async = 1'b0;
    chk({tag, " delivered"}, 32'(got), 32'(nwords));
    chk({tag, " acks"}, 32'(acks), 32'(nwords));
    wait_ack(1'b0, tag);
    chk({tag, " drained"}, {29'd0, bus.count}, 32'd0);
  endtask

  initial begin
    bus.req_async  = 1'b0;
    bus.data_async = 16'h0000;
    bus.out_ready  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst ack", {31'd0, bus.ack}, 32'd0);
    chk("rst valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst count", {29'd0, bus.count}, 32'd0);
    chk("rst data", {16'd0, bus.out_data}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: single transfer latency
    bus.data_async = 16'hA5C3;
    bus.req_async  = 1'b1;
    tick(); chk("T1 ack e1", {31'd0, bus.ack}, 32'd0);
    tick(); chk("T1 ack e2", {31'd0, bus.ack}, 32'd0);
            chk("T1 valid e2", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("T1 ack e3", {31'd0, bus.ack}, 32'd1);
            chk("T1 valid e3", {31'd0, bus.out_valid}, 32'd1);
            chk("T1 data e3", {16'd0, bus.out_data}, 32'h0000A5C3);
            chk("T1 count e3", {29'd0, bus.count}, 32'd1);
    bus.req_async = 1'b0;
    bus.data_async = 16'h1234;
    tick(); chk("T1 ackfall e1", {31'd0, bus.ack}, 32'd1);
    tick(); chk("T1 ackfall e2", {31'd0, bus.ack}, 32'd1);
    tick(); chk("T1 ackfall e3", {31'd0, bus.ack}, 32'd0);
            chk("T1 one push", {29'd0, bus.count}, 32'd1);
    pop_expect(16'hA5C3, "T1 pop");
    chk("T1 empty", {29'd0, bus.count}, 32'd0);

    // Pop on empty is ignored
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    chk("empty pop count", {29'd0, bus.count}, 32'd0);
    chk("empty pop valid", {31'd0, bus.out_valid}, 32'd0);

    // T2: back-pressure
    for (int i = 1; i <= 4; i++) xfer(16'(i), "T2 fill");
    chk("T2 full count", {29'd0, bus.count}, 32'd4);
    bus.data_async = 16'd5;
    bus.req_async  = 1'b1;
    repeat (8) tick();
    chk("T2 stall ack", {31'd0, bus.ack}, 32'd0);
    chk("T2 stall count", {29'd0, bus.count}, 32'd4);
    chk("T2 head", {16'd0, bus.out_data}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("T2 pop edge ack", {31'd0, bus.ack}, 32'd0);
    chk("T2 pop edge count", {29'd0, bus.count}, 32'd3);
    tick();
    chk("T2 late ack", {31'd0, bus.ack}, 32'd1);
    chk("T2 late count", {29'd0, bus.count}, 32'd4);
    bus.req_async = 1'b0;
    wait_ack(1'b0, "T2 release");
    for (int i = 2; i <= 5; i++) pop_expect(16'(i), "T2 drain");
    chk("T2 empty", {31'd0, bus.out_valid}, 32'd0);

    // T3: simultaneous push and pop at count=2
    xfer(16'd10, "T3 a");
    xfer(16'd11, "T3 b");
    chk("T3 count2", {29'd0, bus.count}, 32'd2);
    bus.data_async = 16'd12;
    bus.req_async  = 1'b1;
    tick();
    tick();
    chk("T3 head", {16'd0, bus.out_data}, 32'd10);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("T3 count held", {29'd0, bus.count}, 32'd2);
    chk("T3 ack", {31'd0, bus.ack}, 32'd1);
    chk("T3 new head", {16'd0, bus.out_data}, 32'd11);
    bus.req_async = 1'b0;
    wait_ack(1'b0, "T3 release");
    pop_expect(16'd11, "T3 pop");
    pop_expect(16'd12, "T3 pop");

    // T4: wrap-around with an always-ready consumer
    run_traffic(12, 1'b0, "T4");

    // T6: randomized request / ready timing
    run_traffic(40, 1'b1, "T6");

    // T5: reset while ack=1 and count=3
    xfer(16'd20, "T5 a");
    xfer(16'd21, "T5 b");
    bus.data_async = 16'd22;
    bus.req_async  = 1'b1;
    wait_ack(1'b1, "T5 c");
    chk("T5 count3", {29'd0, bus.count}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("T5 rst ack", {31'd0, bus.ack}, 32'd0);
    chk("T5 rst count", {29'd0, bus.count}, 32'd0);
    chk("T5 rst valid", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("T5 re e1", {31'd0, bus.ack}, 32'd0);
    tick(); chk("T5 re e2", {31'd0, bus.ack}, 32'd0);
    tick(); chk("T5 re e3", {31'd0, bus.ack}, 32'd1);
            chk("T5 re count", {29'd0, bus.count}, 32'd1);
            chk("T5 re data", {16'd0, bus.out_data}, 32'd22);
    bus.req_async = 1'b0;
    wait_ack(1'b0, "T5 release");
    chk("T5 single", {29'd0, bus.count}, 32'd1);
    pop_expect(16'd22, "T5 pop");
    chk("T5 empty", {29'd0, bus.count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
